ssram_master: RTL and testbench
===============================

// Module: ssram_master
// PURPOSE
//  Bus initiator for the ssram_256 register file: accepts single-word read/write requests
//  with a binary address from a local client, decodes them to one-hot row/column selects,
//  and sequences we/re strobes and the shared tri-state data bus. Sits between a CPU/bus
//  bridge and the register file; the only driver of row, column, we, re.
// PARAMETERS
//  WIDTH   16   data word width, matches the register file WIDTH
//  DEPTH   256  number of words implemented in the register file (1..256)
// PORTS
//  clk     in     1      system clock, all logic on rising edge
//  rst     in     1      synchronous reset, active-low
//  req     in     1      request strobe, sampled only in IDLE
//  wr      in     1      1 = write, 0 = read (sampled with req)
//  addr    in     8      word address, row = addr[7:4], column = addr[3:0]
//  wdata   in     WIDTH  write data (sampled with req)
//  rdata   out    WIDTH  read data, valid while ack=1 for a read
//  ack     out    1      one-cycle completion pulse
//  err     out    1      with ack: address >= DEPTH, no access performed
//  busy    out    1      high from cycle after accepted req until ack cycle inclusive
//  row     out    16     one-hot row select to register file
//  column  out    16     one-hot column select to register file
//  we      out    1      write strobe to register file
//  re      out    1      read-enable (bus drive) to register file
//  data    inout  WIDTH  shared data bus; driven here only in write SETUP/ACCESS
// BEHAVIOUR
//  Reset (rst=0 at an edge): state IDLE; rdata=0, ack=0, err=0, busy=0, row=0, column=0,
//   we=0, re=0, data=Z. Applies mid-transaction: access abandoned, no ack produced.
//  States: IDLE, SETUP, ACCESS, HOLD, ERROR.
//  IDLE: all selects/strobes 0, data=Z. req=1 at edge: latch addr, wr, wdata.
//   addr < DEPTH -> SETUP; else -> ERROR. req=0 -> stay.
//  SETUP (1 cycle): row/column one-hot from latched addr; we=re=0; write: data=wdata_l,
//   read: data=Z (turnaround, register file not yet enabled). -> ACCESS.
//  ACCESS (1 cycle): selects held; write: we=1, data=wdata_l, register captures at the
//   closing edge. read: re=1, data=Z, rdata <= data at the closing edge. -> HOLD.
//  HOLD (1 cycle): selects held, we=re=0, data=Z; ack=1, err=0. -> IDLE.
//  ERROR (1 cycle): selects 0, we=re=0, data=Z; ack=1, err=1, rdata unchanged. -> IDLE.
//  Latency: req accepted at edge N -> ack high in cycle N+3 (error: N+1). Next req may be
//   accepted at the edge ending the ack cycle? No: accepted only from IDLE, i.e. edge N+4
//   earliest (error: N+2). req while busy is ignored, not queued.
//  rdata holds its value until the next successful read; writes do not alter it.
//  row and column each have exactly one bit set in SETUP/ACCESS/HOLD, zero otherwise;
//   we and re never high together; data never driven while re=1 (no bus contention).
//  Address decode: row index = addr>>4, column index = addr&15; DEPTH<256 makes upper
//   addresses ERROR even if row/column bits physically exist.
// TESTING
//  1 Reset: hold rst=0 3 cycles with req=1 -> all outputs 0, data=Z, no ack.
//  2 Write addr=8'h00 wdata=16'hA5A5 -> row=0x0001 col=0x0001 in SETUP..HOLD, we=1 only in
//    ACCESS with data=A5A5, ack at req+3; register model word 0 = A5A5.
//  3 Write 8'hFF=16'h1234 then read 8'hFF -> row=0x8000 col=0x8000, re=1 one cycle,
//    rdata=1234 with ack, err=0; back-to-back request accepted 4 cycles after first.
//  4 DEPTH=200, req addr=8'hC8 -> ack+err at req+1, row/col/we/re stay 0, rdata unchanged.
//  5 req held high continuously with changing addr -> only addrs present at IDLE edges
//    accepted; busy=1 between; no missed/duplicated acks.
//  6 rst=0 during ACCESS of a write -> we drops next cycle, no ack; bus-contention checker
//    (data driven by both sides) never fires across all tests.

Source files
------------

// File: rtl/ssram_master.sv
// Bus initiator for the ssram_256 register file: sequences one-hot row/column selects,
// we/re strobes and the shared tri-state data bus for single-word read/write requests.
module ssram_master #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ack,
  output logic             err,
  output logic             busy,
  output logic [15:0]      row,
  output logic [15:0]      column,
  output logic             we,
  output logic             re,
  inout  logic [WIDTH-1:0] data
);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StError} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wr_q;
  logic             ack_q;
  logic             err_q;
  logic             busy_q;
  logic [15:0]      row_q;
  logic [15:0]      column_q;
  logic             we_q;
  logic             re_q;
  logic             drive_q;
  logic             in_range;

  assign in_range = 32'(addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      row_q    <= '0;
      column_q <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      drive_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            wr_q    <= wr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (in_range) begin
              state_q  <= StSetup;
              row_q    <= 16'd1 << addr[7:4];
              column_q <= 16'd1 << addr[3:0];
              // Writes own the bus from SETUP; reads leave it floating for turnaround.
              drive_q  <= wr;
            end else begin
              state_q <= StError;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        StSetup: begin
          state_q <= StAccess;
          we_q    <= wr_q;
          re_q    <= ~wr_q;
        end
        StAccess: begin
          if (!wr_q) begin
            rdata_q <= data;
          end
          state_q <= StHold;
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          drive_q <= 1'b0;
          ack_q   <= 1'b1;
        end
        StHold: begin
          state_q  <= StIdle;
          row_q    <= '0;
          column_q <= '0;
          busy_q   <= 1'b0;
        end
        StError: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          row_q    <= '0;
          column_q <= '0;
          we_q     <= 1'b0;
          re_q     <= 1'b0;
          drive_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data   = drive_q ? wdata_q : 'z;
  assign rdata  = rdata_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign row    = row_q;
  assign column = column_q;
  assign we     = we_q;
  assign re     = re_q;

endmodule

// File: tb/tb_ssram_master.sv
// Randomized scoreboard bench for ssram_master with a behavioural register file on the bus.
module tb_ssram_master;

  localparam int unsigned W = 16;
  localparam int unsigned D = 241;  // row 15 partly valid: 0xF0 ok, 0xF1 errors

  logic          clk = 1'b0;
  logic          rst, req, wr;
  logic [7:0]    addr;
  logic [W-1:0]  wdata, rdata;
  logic          ack, err, busy, we, re;
  logic [15:0]   row, column;
  wire  [W-1:0]  data;

  ssram_master #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .row(row), .column(column),
    .we(we), .re(re), .data(data)
  );

  always #5 clk = ~clk;

  // Register file on the far side of the bus.
  logic [W-1:0] rf [256];
  logic [7:0]   rf_a;

  function automatic logic [3:0] onehot_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  assign rf_a = {onehot_idx(row), onehot_idx(column)};
  assign data = re ? rf[rf_a] : 'z;
  always @(posedge clk) if (we) rf[rf_a] <= data;

  // Reference model: memory contents, visible rdata and the in-flight request.
  typedef struct { int due; logic err; } exp_t;
  typedef struct {
    logic valid; int e; logic wr; logic err; logic [7:0] addr; logic [W-1:0] wdata;
  } op_t;

  exp_t         q[$];
  op_t          cur;
  logic [W-1:0] mem [256];
  logic [W-1:0] mdl_rdata;
  int           cyc, free_at;
  int           checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf[i]  = '0;
      mem[i] = '0;
    end
    cyc       = 0;
    free_at   = 0;
    mdl_rdata = '0;
    cur.valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      // A write lands once ACCESS has closed; a read updates rdata unless reset wins.
      if (cur.valid && !cur.err && cyc == cur.e + 2) begin
        if (cur.wr) mem[cur.addr] = cur.wdata;
        else if (rst) mdl_rdata = mem[cur.addr];
      end
      if (!rst) begin
        cur.valid = 1'b0;
        q.delete();
        mdl_rdata = '0;
        free_at   = 0;
      end else if (req && cyc >= free_at) begin
        cur.valid = 1'b1;
        cur.e     = cyc;
        cur.wr    = wr;
        cur.err   = int'(addr) >= int'(D);
        cur.addr  = addr;
        cur.wdata = wdata;
        q.push_back('{due: cur.err ? cyc : cyc + 2, err: cur.err});
        free_at   = cur.err ? cyc + 2 : cyc + 4;
      end
    end
  end

  // Monitor: compares DUT outputs against the model every cycle, away from the clock edge.
  initial begin
    forever begin
      logic        active, sel, stb;
      logic [15:0] exp_row, exp_col;
      @(negedge clk);
      active  = cur.valid && (cyc <= cur.e + (cur.err ? 0 : 2));
      sel     = active && !cur.err;
      exp_row = sel ? (16'd1 << cur.addr[7:4]) : 16'd0;
      exp_col = sel ? (16'd1 << cur.addr[3:0]) : 16'd0;
      stb     = sel && (cyc == cur.e + 1);
      check("ctrl", {busy, row, column, we, re},
            {active, exp_row, exp_col, stb && cur.wr, stb && !cur.wr});
      check("rdata", rdata, mdl_rdata);
      if (stb && cur.wr) check("wbus", data, cur.wdata);
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_ack at cycle %0d: got no ack expected ack due %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check("ack", {ack, err}, {1'b1, q[0].err});
        void'(q.pop_front());
      end else begin
        check("ack", {ack, err}, 2'b00);
      end
    end
  end

  task automatic drive(input logic r, input logic rq, input logic w, input logic [7:0] a,
                       input logic [W-1:0] d, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r; req = rq; wr = w; addr = a; wdata = d;
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b1; wr = 1'b1; addr = 8'h10; wdata = 16'hFFFF;
    drive(1'b0, 1'b1, 1'b1, 8'h10, 16'hFFFF, 2);
    // Directed: corner addresses, back-to-back, error boundary.
    drive(1'b1, 1'b1, 1'b1, 8'h00, 16'hA5A5, 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 4);
    drive(1'b1, 1'b1, 1'b1, 8'hF0, 16'h1234, 4);
    drive(1'b1, 1'b1, 1'b0, 8'hF0, 16'h0000, 4);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4);
    drive(1'b1, 1'b1, 1'b1, 8'hEF, 16'h0F0F, 4);
    drive(1'b1, 1'b1, 1'b0, 8'hF1, 16'h0000, 2);
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 16'hDEAD, 2);
    drive(1'b1, 1'b1, 1'b0, 8'hEF, 16'h0000, 4);
    // Reset at the edge closing a write ACCESS, then read the word back.
    drive(1'b1, 1'b1, 1'b1, 8'h33, 16'hBEEF, 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1);
    drive(1'b1, 1'b1, 1'b0, 8'h33, 16'h0000, 4);
    // Reset at the edge closing SETUP: the write never happens.
    drive(1'b1, 1'b1, 1'b1, 8'h44, 16'hCAFE, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1);
    drive(1'b1, 1'b1, 1'b0, 8'h44, 16'h0000, 4);
    // Random traffic, req mostly held high, addresses clustered around the DEPTH boundary.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(8'hE8 + $urandom_range(15));
      drive(1'($urandom_range(79) != 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
            a, 16'($urandom), 1);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8);
    check("drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
